// File: rtl/aes_round_sequencer.sv
// Sequences one AES block through an external round core: initial AddRoundKey,
// then nr = 10/12/14 rounds, with decryption walking the key schedule backwards.
module aes_round_sequencer #(
    parameter int MAX_NR  = 14,
    parameter int SCHED_W = (MAX_NR + 1) * 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         switch,
    input  logic               decrypt,
    input  logic [127:0]       data_in,
    input  logic [SCHED_W-1:0] key_d,
    output logic               busy,
    output logic               done,
    output logic [127:0]       data_out,
    output logic [3:0]         round_idx,
    output logic [127:0]       rc_state,
    output logic [127:0]       rc_key,
    output logic               rc_final,
    input  logic [127:0]       rc_result,
    output logic               rc_decrypt,
    output logic               dbg_state
);
    // Handshake: start is sampled only in IDLE. busy is high from the edge that
    // accepts start until the completing or aborting edge. done pulses for the one
    // cycle after the completing edge, with busy already low, so a new start may be
    // presented in that same cycle.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t       r_fsm;
    state_t       w_fsm_next;
    logic [3:0]   r_nr;
    logic [3:0]   r_round;
    logic         r_dec;
    logic         r_done;
    logic [127:0] r_state;
    logic [127:0] r_data_out;
    logic [3:0]   w_nr_in;
    logic [3:0]   w_key_idx;
    logic [127:0] w_key;
    logic [127:0] w_init_key;
    logic         w_last;

    function automatic logic [127:0] key_at(input logic [SCHED_W-1:0] sched,
                                            input logic [3:0] idx);
        key_at = '0;
        for (int k = 0; k <= MAX_NR; k++) begin
            if (idx == 4'(k)) key_at = sched[128*k +: 128];
        end
    endfunction

    always_comb begin
        w_nr_in = 4'd14;
        case (switch)
            2'b00:   w_nr_in = 4'd10;
            2'b01:   w_nr_in = 4'd12;
            default: w_nr_in = 4'd14;
        endcase
    end

    // Decryption uses key nr-r at round r, so the schedule is consumed in reverse.
    assign w_last     = (r_round == r_nr);
    assign w_key_idx  = r_dec ? (r_nr - r_round) : r_round;
    assign w_key      = key_at(key_d, w_key_idx);
    assign w_init_key = key_at(key_d, decrypt ? w_nr_in : 4'd0);

    always_comb begin
        w_fsm_next = r_fsm;
        busy       = 1'b0;
        round_idx  = 4'd0;
        rc_key     = '0;
        rc_final   = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (start) w_fsm_next = S_RUN;
            end
            S_RUN: begin
                busy      = 1'b1;
                round_idx = r_round;
                rc_key    = w_key;
                rc_final  = w_last;
                if (abort || w_last) w_fsm_next = S_IDLE;
            end
            default: w_fsm_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fsm <= S_IDLE;
        else     r_fsm <= w_fsm_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nr       <= 4'd0;
            r_round    <= 4'd0;
            r_dec      <= 1'b0;
            r_done     <= 1'b0;
            r_state    <= '0;
            r_data_out <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (start) begin
                        r_nr    <= w_nr_in;
                        r_dec   <= decrypt;
                        r_state <= data_in ^ w_init_key;
                        r_round <= 4'd1;
                    end
                end
                S_RUN: begin
                    // abort outranks the final round: no result, no done pulse.
                    if (!abort) begin
                        if (w_last) begin
                            r_data_out <= rc_result;
                            r_done     <= 1'b1;
                        end else begin
                            r_state <= rc_result;
                            r_round <= r_round + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign done       = r_done;
    assign data_out   = r_data_out;
    assign rc_state   = r_state;
    assign rc_decrypt = r_dec;
    assign dbg_state  = r_fsm;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: XOR-stub and real AES round-core models,
// FIPS-197 vectors, handshake, abort and asynchronous reset scenarios.
module tb_aes_round_sequencer;
    localparam int MAX_NR  = 14;
    localparam int SCHED_W = (MAX_NR + 1) * 128;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic               clk;
    logic               rst;
    logic               start;
    logic               abort;
    logic [1:0]         switch;
    logic               decrypt;
    logic [127:0]       data_in;
    logic [SCHED_W-1:0] key_d;
    logic               busy;
    logic               done;
    logic [127:0]       data_out;
    logic [3:0]         round_idx;
    logic [127:0]       rc_state;
    logic [127:0]       rc_key;
    logic               rc_final;
    logic [127:0]       rc_result;
    logic               rc_decrypt;
    logic               dbg_state;

    logic               use_real;
    logic [127:0]       last_result;
    logic [127:0]       exp_q[$];
    int                 total;
    int                 bad;

    aes_round_sequencer #(.MAX_NR(MAX_NR), .SCHED_W(SCHED_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .switch(switch),
        .decrypt(decrypt), .data_in(data_in), .key_d(key_d), .busy(busy),
        .done(done), .data_out(data_out), .round_idx(round_idx),
        .rc_state(rc_state), .rc_key(rc_key), .rc_final(rc_final),
        .rc_result(rc_result), .rc_decrypt(rc_decrypt), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- AES reference round core ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (i > 0) r = gmul(r, x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = ginv(x);
        return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] col, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        if (!inv)
            return {gmul(a0,8'h02) ^ gmul(a1,8'h03) ^ a2 ^ a3,
                    a0 ^ gmul(a1,8'h02) ^ gmul(a2,8'h03) ^ a3,
                    a0 ^ a1 ^ gmul(a2,8'h02) ^ gmul(a3,8'h03),
                    gmul(a0,8'h03) ^ a1 ^ a2 ^ gmul(a3,8'h02)};
        return {gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
                gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
                gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
                gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic fin, input logic dec);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (dec) t[r+4*c] = inv_sbox(b[r+4*((c-r+4)%4)]);
                else     t[r+4*c] = sbox(b[r+4*((c+r)%4)]);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        if (dec) o = o ^ k;
        if (!fin) begin
            for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mixcol(o[127-32*c -: 32], dec);
        end
        if (!dec) o = o ^ k;
        return o;
    endfunction

    function automatic logic [SCHED_W-1:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]        w [60];
        logic [31:0]        t;
        logic [7:0]         rc;
        logic [SCHED_W-1:0] sched;
        int                 nr;
        nr    = nk + 6;
        rc    = 8'h01;
        sched = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k <= nr; k++) sched[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return sched;
    endfunction

    always_comb begin
        rc_result = rc_state ^ rc_key;
        if (use_real) rc_result = aes_round(rc_state, rc_key, rc_final, rc_decrypt);
    end

    // ---------------- helpers ----------------
    function automatic logic [127:0] kx(input int j);
        if (j < 0 || j > MAX_NR) return '0;
        return key_d[128*j +: 128];
    endfunction

    function automatic logic [127:0] xor_keys(input int nr);
        logic [127:0] x;
        x = '0;
        for (int j = 0; j <= nr; j++) x = x ^ kx(j);
        return x;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic randomize_keys();
        for (int i = 0; i < SCHED_W/32; i++) key_d[32*i +: 32] = $urandom;
    endtask

    task automatic launch_now(input logic [1:0] sw, input logic dec, input logic [127:0] din);
        start   = 1'b1;
        switch  = sw;
        decrypt = dec;
        data_in = din;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic launch(input logic [1:0] sw, input logic dec, input logic [127:0] din);
        @(negedge clk);
        launch_now(sw, dec, din);
    endtask

    // Returns the number of edges from the accepting edge to the done cycle.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic rand_block(output logic [127:0] d);
        d = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; switch = 2'b00; decrypt = 1'b0;
        data_in = '0; key_d = '0; use_real = 1'b0; last_result = '0;
        #3;
        total++;
        if ({busy, done, rc_final, rc_decrypt, dbg_state} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, rc_final, rc_decrypt, dbg_state});
        end
        total++;
        if (data_out !== 128'h0) begin bad++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        total++;
        if (round_idx !== 4'd0) begin bad++; $display("FAIL reset_round_idx got=%0d exp=0", round_idx); end
        total++;
        if (rc_state !== 128'h0) begin bad++; $display("FAIL reset_rc_state got=%h exp=0", rc_state); end
        total++;
        if (rc_key !== 128'h0) begin bad++; $display("FAIL reset_rc_key got=%h exp=0", rc_key); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_xor_stub();
        logic [127:0] din;
        logic [127:0] exp;
        int lat;
        int r_exp;
        use_real = 1'b0;
        randomize_keys();
        rand_block(din);
        exp_q.push_back(din ^ xor_keys(10));
        launch(2'b00, 1'b0, din);
        lat = 1;
        r_exp = 1;
        while (done !== 1'b1 && lat < 40) begin
            total++;
            if ({round_idx, rc_final, rc_key} !== {4'(r_exp), r_exp == 10, kx(r_exp)}) begin
                bad++;
                $display("FAIL xor_round_seq got idx=%0d final=%b exp idx=%0d final=%b", round_idx, rc_final, r_exp, r_exp == 10);
            end
            @(posedge clk);
            #1;
            lat++;
            r_exp++;
        end
        exp = exp_q.pop_front();
        total++;
        if (lat !== 11) begin bad++; $display("FAIL xor_latency got=%0d exp=11", lat); end
        total++;
        if (data_out !== exp) begin bad++; $display("FAIL xor_data_out got=%h exp=%h", data_out, exp); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL xor_busy_in_done got=%b exp=0", busy); end
        last_result = exp;
        @(posedge clk);
        #1;
        total++;
        if ({done, busy, round_idx, rc_final, rc_key} !== 135'h0) begin
            bad++; $display("FAIL xor_idle_outputs got done=%b busy=%b idx=%0d final=%b key=%h exp all 0", done, busy, round_idx, rc_final, rc_key);
        end
        total++;
        if (data_out !== exp) begin bad++; $display("FAIL xor_data_hold got=%h exp=%h", data_out, exp); end
    endtask

    task automatic test_fips_enc();
        logic [255:0] keys [3];
        logic [127:0] cts [3];
        int           lat;
        keys[0] = KEY1; keys[1] = KEY2; keys[2] = KEY3;
        cts[0]  = CT1;  cts[1]  = CT2;  cts[2]  = CT3;
        use_real = 1'b1;
        for (int v = 0; v < 3; v++) begin
            key_d = expand(keys[v], 4 + 2*v);
            launch(2'(v), 1'b0, PT);
            wait_done(1, lat);
            total++;
            if (lat !== 11 + 2*v) begin bad++; $display("FAIL fips_latency_%0d got=%0d exp=%0d", v, lat, 11 + 2*v); end
            total++;
            if (data_out !== cts[v]) begin bad++; $display("FAIL fips_ct_%0d got=%h exp=%h", v, data_out, cts[v]); end
            last_result = cts[v];
        end
    endtask

    task automatic test_decrypt();
        int lat;
        int r_exp;
        use_real = 1'b1;
        key_d = expand(KEY1, 4);
        launch(2'b00, 1'b1, CT1);
        lat = 1;
        r_exp = 1;
        while (done !== 1'b1 && lat < 40) begin
            total++;
            if ({rc_decrypt, rc_key} !== {1'b1, kx(10 - r_exp)}) begin
                bad++; $display("FAIL dec_key_order r=%0d got dec=%b key=%h exp dec=1 key=%h", r_exp, rc_decrypt, rc_key, kx(10 - r_exp));
            end
            @(posedge clk);
            #1;
            lat++;
            r_exp++;
        end
        total++;
        if (lat !== 11) begin bad++; $display("FAIL dec_latency got=%0d exp=11", lat); end
        total++;
        if (data_out !== PT) begin bad++; $display("FAIL dec_pt got=%h exp=%h", data_out, PT); end
        last_result = PT;
    endtask

    task automatic test_start_busy();
        logic [127:0] din;
        logic [127:0] other;
        logic [127:0] exp;
        int lat;
        int extra;
        use_real = 1'b0;
        randomize_keys();
        rand_block(din);
        rand_block(other);
        exp = din ^ xor_keys(10);
        launch(2'b00, 1'b0, din);
        lat = 1;
        repeat (3) begin @(posedge clk); #1; lat++; end
        start = 1'b1; switch = 2'b10; data_in = other;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        wait_done(lat, lat);
        total++;
        if (lat !== 11) begin bad++; $display("FAIL busy_start_latency got=%0d exp=11", lat); end
        total++;
        if (data_out !== exp) begin bad++; $display("FAIL busy_start_data got=%h exp=%h", data_out, exp); end
        last_result = exp;
        extra = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL busy_start_queued got=%0d active cycles exp=0", extra); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] da;
        logic [127:0] db;
        logic [127:0] exp;
        int lat;
        use_real = 1'b0;
        randomize_keys();
        rand_block(da);
        rand_block(db);
        exp_q.push_back(da ^ xor_keys(10));
        exp_q.push_back(db ^ xor_keys(10));
        launch(2'b00, 1'b0, da);
        wait_done(1, lat);
        exp = exp_q.pop_front();
        total++;
        if (data_out !== exp || lat !== 11) begin bad++; $display("FAIL b2b_first got=%h lat=%0d exp=%h lat=11", data_out, lat, exp); end
        launch_now(2'b00, 1'b0, db);
        total++;
        if ({busy, dbg_state, round_idx} !== {1'b1, 1'b1, 4'd1}) begin
            bad++; $display("FAIL b2b_accept got busy=%b st=%b idx=%0d exp 1 1 1", busy, dbg_state, round_idx);
        end
        wait_done(1, lat);
        exp = exp_q.pop_front();
        total++;
        if (lat !== 11) begin bad++; $display("FAIL b2b_latency got=%0d exp=11", lat); end
        total++;
        if (data_out !== exp) begin bad++; $display("FAIL b2b_second got=%h exp=%h", data_out, exp); end
        last_result = exp;
    endtask

    task automatic test_switch_mid();
        logic [127:0] din;
        logic [127:0] exp;
        int lat;
        use_real = 1'b0;
        randomize_keys();
        rand_block(din);
        exp = din ^ xor_keys(10);
        launch(2'b00, 1'b0, din);
        lat = 1;
        repeat (4) begin @(posedge clk); #1; lat++; end
        switch = 2'b11; decrypt = 1'b1; data_in = ~din;
        wait_done(lat, lat);
        decrypt = 1'b0;
        total++;
        if (lat !== 11) begin bad++; $display("FAIL switch_mid_latency got=%0d exp=11", lat); end
        total++;
        if (data_out !== exp) begin bad++; $display("FAIL switch_mid_data got=%h exp=%h", data_out, exp); end
        last_result = exp;
    endtask

    task automatic test_abort();
        logic [127:0] din;
        int pulses;
        use_real = 1'b0;
        randomize_keys();
        rand_block(din);
        launch(2'b00, 1'b0, din);
        repeat (4) begin @(posedge clk); #1; end
        total++;
        if (round_idx !== 4'd5) begin bad++; $display("FAIL abort_mid_idx got=%0d exp=5", round_idx); end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        total++;
        if ({busy, done, round_idx} !== 6'b0) begin bad++; $display("FAIL abort_mid_stop got busy=%b done=%b idx=%0d exp 0 0 0", busy, done, round_idx); end
        pulses = 0;
        repeat (12) begin @(posedge clk); #1; if (done === 1'b1) pulses++; end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL abort_mid_done got=%0d pulses exp=0", pulses); end
        total++;
        if (data_out !== last_result) begin bad++; $display("FAIL abort_mid_hold got=%h exp=%h", data_out, last_result); end
    endtask

    task automatic test_abort_final();
        logic [127:0] din;
        int pulses;
        use_real = 1'b0;
        randomize_keys();
        rand_block(din);
        launch(2'b00, 1'b0, din);
        repeat (9) begin @(posedge clk); #1; end
        total++;
        if ({round_idx, rc_final} !== {4'd10, 1'b1}) begin bad++; $display("FAIL abort_final_pos got idx=%0d final=%b exp 10 1", round_idx, rc_final); end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        pulses = (done === 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
        if (done === 1'b1) pulses++;
        total++;
        if (pulses !== 0 || busy !== 1'b0) begin bad++; $display("FAIL abort_final_done got pulses=%0d busy=%b exp 0 0", pulses, busy); end
        total++;
        if (data_out !== last_result) begin bad++; $display("FAIL abort_final_hold got=%h exp=%h", data_out, last_result); end
    endtask

    task automatic test_async_reset();
        logic [127:0] din;
        logic [127:0] exp;
        int lat;
        use_real = 1'b0;
        randomize_keys();
        rand_block(din);
        launch(2'b00, 1'b1, din);
        repeat (6) begin @(posedge clk); #1; end
        total++;
        if (round_idx !== 4'd7) begin bad++; $display("FAIL rst_mid_idx got=%0d exp=7", round_idx); end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, rc_final, rc_decrypt, round_idx} !== 8'h0) begin
            bad++; $display("FAIL rst_mid_flags got busy=%b done=%b final=%b dec=%b idx=%0d exp all 0", busy, done, rc_final, rc_decrypt, round_idx);
        end
        total++;
        if ({data_out, rc_state, rc_key} !== 384'h0) begin
            bad++; $display("FAIL rst_mid_buses got data=%h state=%h key=%h exp all 0", data_out, rc_state, rc_key);
        end
        @(negedge clk);
        rst = 1'b0;
        rand_block(din);
        exp = din ^ xor_keys(10);
        launch(2'b00, 1'b0, din);
        wait_done(1, lat);
        total++;
        if (lat !== 11 || data_out !== exp) begin bad++; $display("FAIL rst_restart got=%h lat=%0d exp=%h lat=11", data_out, lat, exp); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_xor_stub();
        test_fips_enc();
        test_decrypt();
        test_start_busy();
        test_back_to_back();
        test_switch_mid();
        test_abort();
        test_abort_final();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
